seq_flag_adder: RTL and testbench

- Parametrised, multi-cycle successor to the 16-bit combinational flag adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, LSB chunk first.
- Registers the result together with sign, zero, carry, parity and overflow flags.
- Start/busy/done handshake; sits between an operand source and a result consumer in the datapath.

---
 rtl/seq_flag_adder.sv | 105 ++++++++++
 tb/tb_seq_flag_adder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_flag_adder.sv
// Multi-cycle add/subtract unit, CHUNK bits per clock, LSB chunk first.
// Registers the result with sign, zero, carry, parity and overflow flags.
module seq_flag_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic             r_cy;
    logic             r_amsb;
    logic             r_bmsb;
    logic [IDXW-1:0]  r_idx;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_res;

    assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_cy};
    // New chunk enters at the top; after NCHUNK shifts the word is aligned.
    assign w_res = WIDTH'({w_sum[CHUNK-1:0], r_part} >> CHUNK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_part   <= '0;
            r_cy     <= 1'b0;
            r_amsb   <= 1'b0;
            r_bmsb   <= 1'b0;
            r_idx    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            c        <= '0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_cy    <= sub;
                        r_amsb  <= a[WIDTH-1];
                        r_bmsb  <= b[WIDTH-1] ^ sub;
                        r_part  <= '0;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a    <= r_a >> CHUNK;
                    r_b    <= r_b >> CHUNK;
                    r_part <= w_res;
                    r_cy   <= w_sum[CHUNK];
                    r_idx  <= r_idx + IDXW'(1);
                    if (r_idx == LAST) begin
                        c        <= w_res;
                        sign     <= w_res[WIDTH-1];
                        zero     <= (w_res == '0);
                        carry    <= w_sum[CHUNK];
                        parity   <= ^w_res;
                        // Operands agree in sign but the result does not.
                        overflow <= (r_amsb == r_bmsb)
                                 && (w_res[WIDTH-1] != r_amsb);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_flag_adder.sv
// Bench for seq_flag_adder: directed 16/4 scenarios plus a 32-bit
// random regression across CHUNK = 1, 8 and 16.
module tb_seq_flag_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] c;
    logic        sign;
    logic        zero;
    logic        carry;
    logic        parity;
    logic        overflow;

    logic        rstart;
    logic        rsub;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rbusy [3];
    logic        rdone [3];
    logic [31:0] rc    [3];
    logic        rs    [3];
    logic        rz    [3];
    logic        rcy   [3];
    logic        rp    [3];
    logic        rov   [3];

    int nvec = 0;
    int nbad = 0;
    int lat  = 0;

    logic [36:0] q[$];
    logic [36:0] rq[3][$];

    seq_flag_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .a(a), .b(b), .busy(busy), .done(done), .c(c),
        .sign(sign), .zero(zero), .carry(carry),
        .parity(parity), .overflow(overflow)
    );

    for (genvar g = 0; g < 3; g++) begin : g_reg
        localparam int CH = (g == 0) ? 1 : ((g == 1) ? 8 : 16);
        seq_flag_adder #(.WIDTH(32), .CHUNK(CH)) u (
            .clk(clk), .rst(rst), .start(rstart), .sub(rsub),
            .a(ra), .b(rb), .busy(rbusy[g]), .done(rdone[g]),
            .c(rc[g]), .sign(rs[g]), .zero(rz[g]), .carry(rcy[g]),
            .parity(rp[g]), .overflow(rov[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int chunk_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 8 : 16);
    endfunction

    // Reference: {c, sign, zero, carry, parity, overflow} for an n-bit op.
    function automatic logic [36:0] model(logic [31:0] x, logic [31:0] y,
                                          logic s, int n);
        logic [63:0] mask;
        logic [63:0] yy;
        logic [63:0] full;
        logic [31:0] r;
        logic        am;
        logic        bm;
        logic        cm;
        logic        ov;
        mask = (64'd1 << n) - 64'd1;
        yy   = s ? (~{32'b0, y}) & mask : {32'b0, y};
        full = {32'b0, x} + yy + {63'b0, s};
        r    = full[31:0] & mask[31:0];
        am   = x[n-1];
        bm   = y[n-1];
        cm   = r[n-1];
        ov   = s ? ((am != bm) && (cm != am)) : ((am == bm) && (cm != am));
        return {r, cm, (r == 32'd0), full[n], ^r, ov};
    endfunction

    function automatic logic [36:0] obs16();
        return {16'b0, c, sign, zero, carry, parity, overflow};
    endfunction

    task automatic chk(string tag, logic [36:0] got, logic [36:0] exp);
        nvec++;
        assert (got === exp) else begin
            nbad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(logic [15:0] x, logic [15:0] y, logic s);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        q.push_back(model({16'b0, x}, {16'b0, y}, s, 16));
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        chk("busy_after_start", {36'b0, busy}, 37'd1);
    endtask

    task automatic wait_done(string tag);
        logic [36:0] e;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            nvec++;
            nbad++;
            $error("FAIL %s: timeout, observed no done expected done", tag);
            if (q.size() > 0) void'(q.pop_front());
        end else begin
            chk({tag, "_lat"}, 37'(lat), 37'd4);
            e = q.pop_front();
            chk(tag, obs16(), e);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sub    = 1'b0;
        a      = '0;
        b      = '0;
        rstart = 1'b0;
        rsub   = 1'b0;
        ra     = '0;
        rb     = '0;
        repeat (2) @(negedge clk);
        chk("reset_out", obs16(), 37'd0);
        chk("reset_hs", {35'b0, busy, done}, 37'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(16'h8fff, 16'h8000, 1'b0); wait_done("add_ovf");
        @(negedge clk);
        launch(16'h6ffe, 16'h0002, 1'b0); wait_done("add_7000");
        @(negedge clk);
        launch(16'haaaa, 16'h5555, 1'b0); wait_done("add_ffff");
        @(negedge clk);
        launch(16'hffff, 16'h0001, 1'b0); wait_done("add_wrap");
        @(negedge clk);
        launch(16'h0000, 16'h0001, 1'b1); wait_done("sub_borrow");
        @(negedge clk);
        launch(16'h8000, 16'h0001, 1'b1); wait_done("sub_ovf");
        @(negedge clk);
        chk("hold_between", obs16(), model(32'h8000, 32'h1, 1'b1, 16));

        launch(16'h1234, 16'h1111, 1'b0);
        @(negedge clk); lat++;
        @(negedge clk); lat++;
        a = 16'hffff; b = 16'hffff; sub = 1'b1; start = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0;
        wait_done("ignore_busy");
        launch(16'h0f0f, 16'hf0f0, 1'b1);
        chk("done_cycle_drop", {36'b0, done}, 37'd0);
        wait_done("done_cycle");

        @(negedge clk);
        launch(16'h4321, 16'h1234, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_rst_out", obs16(), 37'd0);
        chk("midrun_rst_hs", {35'b0, busy, done}, 37'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(16'h7fff, 16'h0001, 1'b0); wait_done("after_rst");

        for (int i = 0; i < 12; i++) begin
            logic [2:0] seen;
            ra   = (i == 0) ? 32'hffff_ffff : $urandom;
            rb   = (i == 0) ? 32'h0000_0001 : $urandom;
            rsub = i[0];
            if (i == 1) begin
                ra = 32'h8000_0000;
                rb = 32'h0000_0001;
            end
            for (int g = 0; g < 3; g++) rq[g].push_back(model(ra, rb, rsub, 32));
            rstart = 1'b1;
            @(negedge clk);
            rstart = 1'b0;
            seen = '0;
            for (int t = 1; t <= 40 && seen != 3'b111; t++) begin
                @(negedge clk);
                for (int g = 0; g < 3; g++) begin
                    if (!seen[g] && rdone[g]) begin
                        logic [36:0] e;
                        seen[g] = 1'b1;
                        e = rq[g].pop_front();
                        chk($sformatf("reg%0d_lat", chunk_of(g)),
                            37'(t), 37'(32 / chunk_of(g)));
                        chk($sformatf("reg%0d_res", chunk_of(g)),
                            {rc[g], rs[g], rz[g], rcy[g], rp[g], rov[g]}, e);
                    end
                end
            end
            for (int g = 0; g < 3; g++) begin
                if (!seen[g]) begin
                    nvec++;
                    nbad++;
                    $error("FAIL reg%0d_timeout: observed no done expected done",
                           chunk_of(g));
                    if (rq[g].size() > 0) void'(rq[g].pop_front());
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
